// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage feeding the main decoder.
// Owns the PC, issues word fetches to instruction memory under a credit
// scheme, buffers returned words in a small in-order queue, and presents
// {pc, instr, opcode} downstream with a valid/ready handshake. A taken branch
// redirects the PC and flushes every word still in flight.
// Optional feature macro: FETCH_BYPASS_EN (same-cycle response bypass when
// the queue is empty). Without it every word passes through the queue.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = PW + 2;
    localparam int SW = DW + 1;

    localparam logic [31:0]   NOP_INSTR   = 32'h0000_0013;
    localparam logic [CW:0]   LP_QDEPTH   = (CW+1)'(QDEPTH);
    localparam logic [SW-1:0] LP_DROP_MAX = SW'(2 * QDEPTH);

    // Architectural fetch state
    logic [31:0]   r_pc;
    logic [31:0]   r_rspPc;
    logic [31:0]   r_lastPc;
    logic [CW-1:0] r_outstanding;
    logic [DW-1:0] r_drop;

    // In-order instruction queue
    logic [31:0]   r_qPc    [QDEPTH];
    logic [31:0]   r_qInstr [QDEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Per-cycle decisions
    logic          w_empty;
    logic          w_credit;
    logic          w_accept;
    logic          w_rspDrop;
    logic          w_rspLive;
    logic          w_bypass;
    logic          w_popQ;
    logic          w_push;
    logic [31:0]   w_redirectPc;
    logic [SW-1:0] w_dropSum;
    logic [DW-1:0] w_dropSat;

    assign w_empty      = (r_count == '0);
    assign w_credit     = ({1'b0, r_count} + {1'b0, r_outstanding}) < LP_QDEPTH;
    assign w_accept     = imem_req_valid & imem_req_ready;
    assign w_rspDrop    = imem_rsp_valid & (r_drop != '0);
    assign w_rspLive    = imem_rsp_valid & (r_drop == '0) & (r_outstanding != '0);
    assign w_redirectPc = redirect_pc & ~32'h0000_0003;

    assign imem_req_valid = ~rst & w_credit;
    assign imem_req_addr  = r_pc;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_empty & w_rspLive & ~redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_popQ = ~w_empty & if_ready & ~redirect_valid;
    assign w_push = w_rspLive & ~redirect_valid & ~(w_bypass & if_ready);

    // Everything still in flight after this cycle becomes a word to discard on redirect
    always_comb begin
        w_dropSum = SW'(r_drop) + SW'(r_outstanding) + SW'(w_accept)
                  - SW'(w_rspDrop | w_rspLive);
        w_dropSat = DW'(w_dropSum);
        if (w_dropSum > LP_DROP_MAX) begin
            w_dropSat = DW'(LP_DROP_MAX);
        end
    end

    // Downstream presentation: queue head, else bypassed response, else NOP with last PC
    always_comb begin
        if_valid = 1'b0;
        if_pc    = r_lastPc;
        if_instr = NOP_INSTR;
        if (!w_empty) begin
            if_valid = 1'b1;
            if_pc    = r_qPc[r_head];
            if_instr = r_qInstr[r_head];
        end else if (w_bypass) begin
            if_valid = 1'b1;
            if_pc    = r_rspPc;
            if_instr = imem_rsp_data;
        end
    end

    assign if_opcode = if_instr[6:0];

    // PC advances on accepted requests; a redirect overrides with the aligned target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirectPc;
        end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // PC of the next live response; responses return in request order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspPc <= RESET_PC;
        end else if (redirect_valid) begin
            r_rspPc <= w_redirectPc;
        end else if (w_rspLive) begin
            r_rspPc <= r_rspPc + 32'd4;
        end
    end

    // Live request count and count of stale responses still to be discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            r_outstanding <= '0;
            r_drop        <= w_dropSat;
        end else begin
            if (w_accept && !w_rspLive) begin
                r_outstanding <= r_outstanding + CW'(1);
            end else if (!w_accept && w_rspLive) begin
                r_outstanding <= r_outstanding - CW'(1);
            end
            if (w_rspDrop) begin
                r_drop <= r_drop - DW'(1);
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_popQ) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_popQ) begin
                r_count <= r_count + CW'(1);
            end else if (w_popQ && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Queue storage needs no reset: entries are only read while counted as occupied
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qPc[r_tail]    <= r_rspPc;
            r_qInstr[r_tail] <= imem_rsp_data;
        end
    end

    // Remember the last presented PC so it holds while the queue is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastPc <= '0;
        end else if (if_valid) begin
            r_lastPc <= if_pc;
        end
    end

    a_dropBound: assert property (@(posedge clk) disable iff (rst)
        redirect_valid |-> (w_dropSum <= LP_DROP_MAX));

endmodule
